// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// A flush turns every held slot into a bubble by clearing control bits; data payloads are held.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;
    logic w_clr_main;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Next-state and load-enable decode; flush overrides every transition.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_load_main_in = 1'b1;
                        w_state_nxt    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = ST_TWO;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_fire) begin
                        w_load_main_skid = 1'b1;
                        w_state_nxt      = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Keeping main control at zero whenever the stage is empty lets out_ctrl come straight from a flop.
    assign w_clr_main = (w_state_nxt == ST_EMPTY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
        end else if (w_clr_main) begin
            r_main_ctrl <= '0;
        end else if (w_load_main_in) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
        end else if (w_load_main_skid) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            r_skid_ctrl <= '0;
        end else if (w_load_skid) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_ctrl;
    assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: the driver queues each entry it expects to be accepted,
// and a monitor pops and compares on every output transfer.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned CTRL_W = 2;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_fires  = 0;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        exp_t e;
        e.d = d;
        e.c = c;
        exp_q.push_back(e);
    endtask

    // Monitor: a transfer seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && out_ready) begin
                n_fires++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {62'd0, out_ctrl}, 64'hdead);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e.d));
                    check("out_ctrl", 64'(out_ctrl), 64'(e.c));
                end
            end
            if (!out_valid) check("ctrl_zero_when_invalid", 64'(out_ctrl), 64'd0);
            if (flush) exp_q.delete();
        end
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset and pass-through
        repeat (3) tick();
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_ctrl",  64'(out_ctrl),  64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        #3 reset = 1'b1;
        tick();
        check("in_ready_after_release", 64'(in_ready), 64'd1);

        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h1234;
        in_ctrl   = 2'b11;
        expect_entry(64'h1234, 2'b11);
        tick();
        in_valid = 1'b0;
        check("pt_out_valid", 64'(out_valid), 64'd1);
        check("pt_out_data",  64'(out_data),  64'h1234);
        check("pt_out_ctrl",  64'(out_ctrl),  64'd3);
        tick();
        check("pt_drained_valid", 64'(out_valid), 64'd0);
        check("pt_drained_occ",   64'(occupancy), 64'd0);

        // Streaming: one entry per cycle, never entering TWO
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            in_ctrl  = 2'(i);
            expect_entry(64'(i), 2'(i));
            tick();
            check("stream_in_ready", 64'(in_ready), 64'd1);
            check("stream_occ_le1", 64'(occupancy <= 2'd1), 64'd1);
        end
        in_valid = 1'b0;
        repeat (2) tick();
        check("stream_queue_empty", 64'(exp_q.size()), 64'd0);
        check("stream_fire_count",  64'(n_fires), 64'd9);

        // Skid fill: A then B with out_ready low; C must wait
        in_valid = 1'b1;
        in_data  = 64'hA;
        in_ctrl  = 2'b01;
        expect_entry(64'hA, 2'b01);
        tick();
        out_ready = 1'b0;
        in_data   = 64'hB;
        in_ctrl   = 2'b10;
        expect_entry(64'hB, 2'b10);
        tick();
        check("skid_occ2",     64'(occupancy), 64'd2);
        check("skid_in_ready", 64'(in_ready),  64'd0);
        check("skid_head_a",   64'(out_data),  64'hA);
        in_data = 64'hC;
        in_ctrl = 2'b11;
        tick();
        check("skid_c_blocked_occ", 64'(occupancy), 64'd2);
        check("skid_c_blocked_rdy", 64'(in_ready),  64'd0);
        check("skid_still_a",       64'(out_data),  64'hA);
        out_ready = 1'b1;
        tick();
        check("skid_head_b",     64'(out_data), 64'hB);
        check("skid_ready_back", 64'(in_ready), 64'd1);
        expect_entry(64'hC, 2'b11);
        tick();
        in_valid = 1'b0;
        check("skid_head_c", 64'(out_data), 64'hC);
        repeat (2) tick();
        check("skid_queue_empty", 64'(exp_q.size()), 64'd0);

        // Flush with two entries and a concurrent input
        in_valid = 1'b1;
        in_data  = 64'h1D;
        in_ctrl  = 2'b01;
        expect_entry(64'h1D, 2'b01);
        tick();
        out_ready = 1'b0;
        in_data   = 64'h1E;
        in_ctrl   = 2'b10;
        expect_entry(64'h1E, 2'b10);
        tick();
        check("flush_pre_occ2", 64'(occupancy), 64'd2);
        flush   = 1'b1;
        in_data = 64'h1F;
        in_ctrl = 2'b11;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_out_ctrl",  64'(out_ctrl),  64'd0);
        check("flush_occ",       64'(occupancy), 64'd0);
        check("flush_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        check("flush_no_ghost", 64'(out_valid), 64'd0);

        // Asynchronous reset while two entries are held
        in_valid = 1'b1;
        in_data  = 64'h77;
        in_ctrl  = 2'b01;
        expect_entry(64'h77, 2'b01);
        tick();
        out_ready = 1'b0;
        in_data   = 64'h88;
        in_ctrl   = 2'b10;
        expect_entry(64'h88, 2'b10);
        tick();
        in_valid = 1'b0;
        check("arst_pre_occ2", 64'(occupancy), 64'd2);
        #2 reset = 1'b0;
        exp_q.delete();
        #1;
        check("arst_in_ready",  64'(in_ready),  64'd0);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_data",  64'(out_data),  64'd0);
        check("arst_out_ctrl",  64'(out_ctrl),  64'd0);
        check("arst_occ",       64'(occupancy), 64'd0);
        repeat (2) tick();
        #3 reset = 1'b1;
        out_ready = 1'b1;
        tick();
        check("arst_release_ready", 64'(in_ready), 64'd1);
        repeat (2) tick();
        check("arst_no_stale", 64'(out_valid), 64'd0);

        // Recovery transfer after reset
        in_valid = 1'b1;
        in_data  = 64'h55;
        in_ctrl  = 2'b10;
        expect_entry(64'h55, 2'b10);
        tick();
        in_valid = 1'b0;
        check("recover_data", 64'(out_data), 64'h55);
        repeat (2) tick();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
